// File: rtl/key_rst_pkg.sv
// Shared types and sizing helpers for the key-driven reset sequencer.
package key_rst_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 240000;
   localparam int DEF_HOLD_CYCLES     = 12;
   localparam int DEF_STAGE_CYCLES    = 1200;
   localparam int DEF_NUM_DOMAINS     = 3;

   // Width of a counter that only ever holds 0..n-1.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int DEF_DB_CNT_W  = cnt_width(DEF_DEBOUNCE_CYCLES);
   localparam int DEF_SEQ_CNT_W = cnt_width(max_int(DEF_HOLD_CYCLES, DEF_STAGE_CYCLES));

endpackage

// File: rtl/key_debounce.sv
// One raw active-low key: 2-FF synchronizer followed by a mismatch-run debounce counter.
module key_debounce
   import key_rst_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic key_db
);

   localparam int CNT_W = (DEBOUNCE_CYCLES == DEF_DEBOUNCE_CYCLES) ? DEF_DB_CNT_W
                                                                    : cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         cnt    <= '0;
         key_db <= 1'b1;
      end else begin
         sync_1 <= key_raw;
         sync_2 <= sync_1;
         if (sync_2 == key_db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            key_db <= sync_2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_rst_sequencer.sv
// Board reset controller: debounced key-code trigger, minimum hold, then staged
// per-domain release (bit 0 first).
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_HOLD    | all domains in reset; waits HOLD_CYCLES and for combo release
//   ST_RELEASE | one more domain released every STAGE_CYCLES
//   ST_RUN     | all domains out of reset; combo re-enters ST_HOLD
module key_rst_sequencer
   import key_rst_pkg::*;
#(
   parameter int         DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int         HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int         STAGE_CYCLES    = DEF_STAGE_CYCLES,
   parameter int         NUM_DOMAINS     = DEF_NUM_DOMAINS,
   parameter logic [3:0] RST_CODE        = 4'b1110
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [3:0]             key_in,
   output logic [NUM_DOMAINS-1:0] rst_out_n,
   output logic                   busy,
   output logic [3:0]             key_db,
   output logic [7:0]             rst_count
);

   localparam int SEQ_CNT_W = cnt_width(max_int(HOLD_CYCLES, STAGE_CYCLES));
   localparam int IDX_W     = cnt_width(NUM_DOMAINS);

   localparam logic [SEQ_CNT_W-1:0] HOLD_LAST  = SEQ_CNT_W'(HOLD_CYCLES - 1);
   localparam logic [SEQ_CNT_W-1:0] STAGE_LAST = SEQ_CNT_W'(STAGE_CYCLES - 1);
   localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_DOMAINS - 1);

   state_t                 state, state_nxt;
   logic [SEQ_CNT_W-1:0]   cnt, cnt_nxt;
   logic [IDX_W-1:0]       idx, idx_nxt;
   logic [NUM_DOMAINS-1:0] rst_out_n_nxt;
   logic                   busy_nxt;
   logic [7:0]             rst_count_nxt;
   logic                   combo;

   for (genvar i = 0; i < 4; i++) begin : gen_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_key_debounce (
         .clk     (clk),
         .rst     (rst),
         .key_raw (key_in[i]),
         .key_db  (key_db[i])
      );
   end

   assign combo = (key_db == RST_CODE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_HOLD;
         cnt       <= '0;
         idx       <= '0;
         rst_out_n <= '0;
         busy      <= 1'b1;
         rst_count <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         rst_out_n <= rst_out_n_nxt;
         busy      <= busy_nxt;
         rst_count <= rst_count_nxt;
      end
   end

   // The hold exit requires combo low, so a held combo can never count twice.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      idx_nxt       = idx;
      rst_out_n_nxt = rst_out_n;
      busy_nxt      = busy;
      rst_count_nxt = rst_count;

      if (state != ST_HOLD && combo) begin
         state_nxt     = ST_HOLD;
         cnt_nxt       = '0;
         idx_nxt       = '0;
         rst_out_n_nxt = '0;
         busy_nxt      = 1'b1;
         if (rst_count != 8'hFF) begin
            rst_count_nxt = rst_count + 8'd1;
         end
      end else begin
         unique case (state)
            ST_HOLD: begin
               if (cnt != HOLD_LAST) begin
                  cnt_nxt = cnt + 1'b1;
               end else if (!combo) begin
                  cnt_nxt          = '0;
                  rst_out_n_nxt[0] = 1'b1;
                  if (NUM_DOMAINS == 1) begin
                     state_nxt = ST_RUN;
                     busy_nxt  = 1'b0;
                  end else begin
                     state_nxt = ST_RELEASE;
                     idx_nxt   = IDX_W'(1);
                  end
               end
            end
            ST_RELEASE: begin
               if (cnt == STAGE_LAST) begin
                  cnt_nxt            = '0;
                  rst_out_n_nxt[idx] = 1'b1;
                  if (idx == IDX_LAST) begin
                     state_nxt = ST_RUN;
                     busy_nxt  = 1'b0;
                  end else begin
                     idx_nxt = idx + 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            ST_RUN: begin
               rst_out_n_nxt = '1;
               busy_nxt      = 1'b0;
            end
            default: begin
               state_nxt     = ST_HOLD;
               cnt_nxt       = '0;
               idx_nxt       = '0;
               rst_out_n_nxt = '0;
               busy_nxt      = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_rst_sequencer.sv
// Self-checking bench: directed scenarios plus random key traffic, compared each
// cycle against a timeline model of debounce, hold and staged release.
module tb_key_rst_sequencer;

   localparam int         D    = 4;
   localparam int         H    = 3;
   localparam int         S    = 2;
   localparam int         N    = 3;
   localparam logic [3:0] CODE = 4'b1110;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   key_in = 4'b1111;
   logic [N-1:0] rst_out_n;
   logic         busy;
   logic [3:0]   key_db;
   logic [7:0]   rst_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   key_rst_sequencer #(
      .DEBOUNCE_CYCLES (D),
      .HOLD_CYCLES     (H),
      .STAGE_CYCLES    (S),
      .NUM_DOMAINS     (N),
      .RST_CODE        (CODE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .rst_out_n (rst_out_n),
      .busy      (busy),
      .key_db    (key_db),
      .rst_count (rst_count)
   );

   // Model: keys reach the debouncer two edges late; a key is accepted after D
   // consecutive differing samples. Reset timeline is tracked as "edges spent in
   // hold" and "edges since hold ended"; released domains = 1 + since/S.
   logic [3:0] m_s1, m_s2, m_db;
   int         m_run [4];
   bit         m_hold;
   bit         m_combo;
   int         m_age;
   int         m_since;
   int         m_count;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_s1 = 4'hF; m_s2 = 4'hF; m_db = 4'hF;
         for (int i = 0; i < 4; i++) m_run[i] = 0;
         m_hold = 1'b1; m_age = 0; m_since = 0; m_count = 0;
      end else begin
         m_combo = (m_db == CODE);
         if (m_hold) begin
            if (m_age >= H - 1 && !m_combo) begin
               m_hold  = 1'b0;
               m_since = 0;
            end else begin
               m_age++;
            end
         end else if (m_combo) begin
            m_hold = 1'b1;
            m_age  = 0;
            if (m_count < 255) m_count++;
         end else if (m_since < 100000) begin
            m_since++;
         end
         for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_db[i]) begin
               m_run[i]++;
               if (m_run[i] == D) begin
                  m_db[i]  = m_s2[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = key_in;
      end
   end

   function automatic logic [N-1:0] exp_rst();
      int rel;
      if (m_hold) return '0;
      rel = 1 + m_since / S;
      if (rel > N) rel = N;
      return N'((1 << rel) - 1);
   endfunction

   function automatic logic exp_busy();
      return m_hold || (1 + m_since / S < N);
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         n_checks++;
         if (rst_out_n !== exp_rst() || busy !== exp_busy() ||
             key_db !== m_db || rst_count !== 8'(m_count)) begin
            n_errors++;
            $display("FAIL cycle_compare t=%0t (got/exp) rst_out_n=%b/%b busy=%b/%b key_db=%b/%b rst_count=%0d/%0d",
                     $time, rst_out_n, exp_rst(), busy, exp_busy(), key_db, m_db, rst_count, m_count);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      int w;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rst_out_n", 32'(rst_out_n), 32'h0);
      check("reset_busy", 32'(busy), 32'h1);
      check("reset_key_db", 32'(key_db), 32'hF);
      @(negedge clk) rst = 1'b0;

      // power-on release: bit 0 at edge 3, bit 1 at 5, bit 2 at 7
      edges(2); check("por_edge2", 32'(rst_out_n), 32'b000);
      edges(1); check("por_edge3", 32'(rst_out_n), 32'b001);
      check("model_por_edge3", 32'(exp_rst()), 32'b001);
      edges(2); check("por_edge5", 32'(rst_out_n), 32'b011);
      check("por_edge5_busy", 32'(busy), 32'h1);
      edges(2); check("por_edge7", 32'(rst_out_n), 32'b111);
      check("por_edge7_busy", 32'(busy), 32'h0);
      check("por_count", 32'(rst_count), 32'h0);

      // 3-cycle glitch on the code is filtered
      @(negedge clk) key_in = CODE;
      repeat (3) @(posedge clk);
      @(negedge clk) key_in = 4'hF;
      edges(10);
      check("glitch_key_db", 32'(key_db), 32'hF);
      check("glitch_rst", 32'(rst_out_n), 32'b111);
      check("glitch_count", 32'(rst_count), 32'h0);

      // all keys pressed is not the code
      @(negedge clk) key_in = 4'b0000;
      edges(20);
      check("wrong_key_db", 32'(key_db), 32'h0);
      check("wrong_rst", 32'(rst_out_n), 32'b111);
      check("wrong_count", 32'(rst_count), 32'h0);
      @(negedge clk) key_in = 4'hF;
      edges(8);
      check("wrong_release_db", 32'(key_db), 32'hF);

      // trigger from RUN: key_db after 6 edges, reset one edge later
      @(negedge clk) key_in = CODE;
      edges(5); check("trig_db_edge5", 32'(key_db), 32'hF);
      edges(1); check("trig_db_edge6", 32'(key_db), 32'(CODE));
      check("trig_rst_edge6", 32'(rst_out_n), 32'b111);
      edges(1); check("trig_rst_edge7", 32'(rst_out_n), 32'b000);
      check("trig_count", 32'(rst_count), 32'h1);
      check("model_trig_count", 32'(m_count), 32'h1);
      edges(10);
      check("trig_held_rst", 32'(rst_out_n), 32'b000);
      @(negedge clk) key_in = 4'hF;
      edges(6); check("rel_db_edge6", 32'(key_db), 32'hF);
      check("rel_rst_edge6", 32'(rst_out_n), 32'b000);
      edges(1); check("rel_rst_edge7", 32'(rst_out_n), 32'b001);
      edges(4); check("rel_rst_edge11", 32'(rst_out_n), 32'b111);
      check("rel_count", 32'(rst_count), 32'h1);

      // abort mid-release; debounce spacing makes 011 the earliest reachable point
      @(negedge clk) key_in = CODE;
      edges(7); check("abort_setup_count", 32'(rst_count), 32'h2);
      edges(10);
      @(negedge clk) key_in = 4'hF;
      repeat (4) @(posedge clk);
      @(negedge clk) key_in = CODE;
      edges(5); check("abort_edge9_rst", 32'(rst_out_n), 32'b011);
      edges(1); check("abort_edge10_db", 32'(key_db), 32'(CODE));
      check("abort_edge10_rst", 32'(rst_out_n), 32'b011);
      edges(1); check("abort_edge11_rst", 32'(rst_out_n), 32'b000);
      check("abort_busy", 32'(busy), 32'h1);
      check("abort_count", 32'(rst_count), 32'h3);

      // async reset between edges while releasing
      edges(5);
      @(negedge clk) key_in = 4'hF;
      w = 0;
      while (rst_out_n !== 3'b011 && w < 40) begin
         @(negedge clk);
         w++;
      end
      check("wait_011", 32'(rst_out_n), 32'b011);
      #1 rst = 1'b1;
      #1;
      check("async_rst_out_n", 32'(rst_out_n), 32'h0);
      check("async_busy", 32'(busy), 32'h1);
      check("async_key_db", 32'(key_db), 32'hF);
      check("async_count", 32'(rst_count), 32'h0);
      #1 rst = 1'b0;
      edges(3); check("repor_edge3", 32'(rst_out_n), 32'b001);
      edges(4); check("repor_edge7", 32'(rst_out_n), 32'b111);
      check("repor_busy", 32'(busy), 32'h0);

      // random key traffic, checked cycle by cycle against the model
      for (int seg = 0; seg < 60; seg++) begin
         int sel;
         int dur;
         sel = $urandom_range(0, 3);
         dur = $urandom_range(1, 15);
         @(negedge clk);
         case (sel)
            0: key_in = 4'hF;
            1: key_in = CODE;
            2: key_in = 4'($urandom());
            default: key_in = 4'h0;
         endcase
         repeat (dur) @(posedge clk);
      end
      @(negedge clk) key_in = 4'hF;
      edges(30);
      check("final_rst", 32'(rst_out_n), 32'b111);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
